planificador_llamadas: RTL and testbench

// Call scheduler for the 4-floor elevator controller (maquina_estados).
// - Latches floor-call buttons and keeps the pending set.
// - Uses a SCAN policy (keep direction while calls remain ahead) to pick the next target floor.
// - Presents the target to the elevator FSM and retires each call once the car is stopped at that floor with doors open.

---
 rtl/elevador_pkg.sv | 27 ++
 rtl/buscador_piso.sv | 65 ++++++
 rtl/planificador_llamadas.sv | 123 ++++++++++++
 tb/tb_planificador_llamadas.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/elevador_pkg.sv
// Shared definitions for the elevator controller: scheduler states,
// direction codes and the motion codes reported by the elevator FSM.
package elevador_pkg;

    typedef enum logic [1:0] {
        REPOSO   = 2'b00,
        SUBIENDO = 2'b01,
        BAJANDO  = 2'b10
    } estado_t;

    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    localparam logic [1:0] ACC_PARADO = 2'b00;
    localparam logic [1:0] ACC_SUBE   = 2'b01;
    localparam logic [1:0] ACC_BAJA   = 2'b10;

    function automatic logic [1:0] dir_de_estado(input estado_t e);
        case (e)
            SUBIENDO: return DIR_UP;
            BAJANDO:  return DIR_DOWN;
            default:  return DIR_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/buscador_piso.sv
// Combinational search over the pending-call set relative to the current floor:
// SCAN candidates in both directions plus the nearest other floor (ties go up).
module buscador_piso
    import elevador_pkg::*;
#(
    parameter int N_PISOS = 4,
    parameter int PISO_W  = 2
) (
    input  logic [N_PISOS-1:0] pendientes,
    input  logic [PISO_W-1:0]  piso,
    output logic [PISO_W-1:0]  piso_arriba,
    output logic               hay_arriba,
    output logic [PISO_W-1:0]  piso_abajo,
    output logic               hay_abajo,
    output logic               hay_mayor,
    output logic               hay_menor,
    output logic [PISO_W-1:0]  piso_cercano,
    output logic               hay_cercano,
    output logic               cercano_sube
);

    always_comb begin
        int unsigned p;
        int unsigned d;
        int unsigned mejor;
        p            = 32'(piso);
        d            = 0;
        mejor        = 0;
        piso_arriba  = '0;
        hay_arriba   = 1'b0;
        piso_abajo   = '0;
        hay_abajo    = 1'b0;
        hay_mayor    = 1'b0;
        hay_menor    = 1'b0;
        piso_cercano = '0;
        hay_cercano  = 1'b0;
        cercano_sube = 1'b0;
        // Ascending scan: first hit >= piso is the lowest, last hit <= piso is the highest.
        for (int unsigned i = 0; i < N_PISOS; i++) begin
            if (pendientes[i]) begin
                if (i >= p && !hay_arriba) begin
                    piso_arriba = PISO_W'(i);
                    hay_arriba  = 1'b1;
                end
                if (i <= p) begin
                    piso_abajo = PISO_W'(i);
                    hay_abajo  = 1'b1;
                end
                if (i > p) hay_mayor = 1'b1;
                if (i < p) hay_menor = 1'b1;
                if (i != p) begin
                    d = (i > p) ? i - p : p - i;
                    // An equal-distance floor above replaces the one below.
                    if (!hay_cercano || d < mejor || (d == mejor && i > p)) begin
                        piso_cercano = PISO_W'(i);
                        hay_cercano  = 1'b1;
                        cercano_sube = (i > p);
                        mejor        = d;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/planificador_llamadas.sv
// SCAN call scheduler for the elevator FSM: latches calls, picks the next
// target floor and retires a call once the car stands at it with doors open.
module planificador_llamadas
    import elevador_pkg::*;
#(
    parameter int N_PISOS = 4,
    parameter int PISO_W  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [N_PISOS-1:0] llamada,
    input  logic [PISO_W-1:0]  piso,
    input  logic [1:0]         accion,
    input  logic               puertas,
    output logic [PISO_W-1:0]  objetivo,
    output logic               objetivo_valido,
    output logic [1:0]         direccion,
    output logic [N_PISOS-1:0] pendientes
);

    estado_t             estado, estado_sig;
    logic [PISO_W-1:0]   objetivo_sig;
    logic                valido_sig;
    logic                piso_ok;
    logic [N_PISOS-1:0]  actual, servido, pend_sig;

    logic [PISO_W-1:0]   piso_arriba, piso_abajo, piso_cercano;
    logic                hay_arriba, hay_abajo, hay_mayor, hay_menor;
    logic                hay_cercano, cercano_sube;

    buscador_piso #(
        .N_PISOS (N_PISOS),
        .PISO_W  (PISO_W)
    ) u_buscador (
        .pendientes   (pendientes),
        .piso         (piso),
        .piso_arriba  (piso_arriba),
        .hay_arriba   (hay_arriba),
        .piso_abajo   (piso_abajo),
        .hay_abajo    (hay_abajo),
        .hay_mayor    (hay_mayor),
        .hay_menor    (hay_menor),
        .piso_cercano (piso_cercano),
        .hay_cercano  (hay_cercano),
        .cercano_sube (cercano_sube)
    );

    assign piso_ok  = 32'(piso) < N_PISOS;
    assign actual   = piso_ok ? (N_PISOS'(1) << piso) : '0;
    assign servido  = (accion == ACC_PARADO && puertas) ? actual : '0;
    // Clearing has priority, so a press at the open floor is absorbed.
    assign pend_sig = (pendientes | llamada) & ~servido;

    always_comb begin
        estado_sig   = estado;
        objetivo_sig = objetivo;
        valido_sig   = objetivo_valido;
        if (piso_ok) begin
            case (estado)
                REPOSO: begin
                    if (pendientes == '0) begin
                        valido_sig = 1'b0;
                    end else if (pendientes == actual) begin
                        objetivo_sig = piso;
                        valido_sig   = 1'b1;
                    end else if (hay_cercano) begin
                        estado_sig   = cercano_sube ? SUBIENDO : BAJANDO;
                        objetivo_sig = piso_cercano;
                        valido_sig   = 1'b1;
                    end
                end
                SUBIENDO: begin
                    if (hay_arriba) begin
                        objetivo_sig = piso_arriba;
                        valido_sig   = 1'b1;
                    end else if (hay_menor) begin
                        estado_sig   = BAJANDO;
                        objetivo_sig = piso_abajo;
                        valido_sig   = 1'b1;
                    end else begin
                        estado_sig = REPOSO;
                        valido_sig = 1'b0;
                    end
                end
                BAJANDO: begin
                    if (hay_abajo) begin
                        objetivo_sig = piso_abajo;
                        valido_sig   = 1'b1;
                    end else if (hay_mayor) begin
                        estado_sig   = SUBIENDO;
                        objetivo_sig = piso_arriba;
                        valido_sig   = 1'b1;
                    end else begin
                        estado_sig = REPOSO;
                        valido_sig = 1'b0;
                    end
                end
                default: begin
                    estado_sig = REPOSO;
                    valido_sig = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pendientes      <= '0;
            estado          <= REPOSO;
            objetivo        <= '0;
            objetivo_valido <= 1'b0;
            direccion       <= DIR_IDLE;
        end else if (en) begin
            pendientes      <= pend_sig;
            estado          <= estado_sig;
            objetivo        <= objetivo_sig;
            objetivo_valido <= valido_sig;
            direccion       <= dir_de_estado(estado_sig);
        end
    end

endmodule

// File: tb/tb_planificador_llamadas.sv
// Directed bench for planificador_llamadas: stimulus queues the expected
// outputs for the next edge, a negedge monitor pops and compares them.
module tb_planificador_llamadas;

  logic       clk = 1'b0;
  logic       rst, en, puertas;
  logic [3:0] llamada;
  logic [1:0] piso, accion;
  logic [1:0] objetivo;
  logic       objetivo_valido;
  logic [1:0] direccion;
  logic [3:0] pendientes;

  typedef struct {
    string      nombre;
    int         cyc;
    logic [3:0] pend;
    logic [1:0] obj;
    logic       val;
    logic [1:0] dir;
  } exp_t;

  exp_t q[$];
  int   ciclo  = 0;
  int   checks = 0;
  int   fails  = 0;

  planificador_llamadas #(
    .N_PISOS (4),
    .PISO_W  (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .llamada         (llamada),
    .piso            (piso),
    .accion          (accion),
    .puertas         (puertas),
    .objetivo        (objetivo),
    .objetivo_valido (objetivo_valido),
    .direccion       (direccion),
    .pendientes      (pendientes)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ciclo <= ciclo + 1;

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= ciclo) begin
      e = q.pop_front();
      checks++;
      if (e.cyc != ciclo ||
          {pendientes, objetivo, objetivo_valido, direccion} !== {e.pend, e.obj, e.val, e.dir}) begin
        fails++;
        $display("FAIL %s (edge %0d): pend=%b obj=%0d val=%b dir=%b, expected pend=%b obj=%0d val=%b dir=%b",
                 e.nombre, e.cyc, pendientes, objetivo, objetivo_valido, direccion,
                 e.pend, e.obj, e.val, e.dir);
      end
    end
  end

  task automatic espera(input string n, input logic [3:0] p, input logic [1:0] o,
                        input logic v, input logic [1:0] d);
    exp_t e;
    e.nombre = n;
    e.cyc    = ciclo + 1;
    e.pend   = p;
    e.obj    = o;
    e.val    = v;
    e.dir    = d;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fsm(input logic [1:0] f, input logic [1:0] a, input logic pu);
    piso    = f;
    accion  = a;
    puertas = pu;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; llamada = 4'b1111;
    fsm(2'd0, 2'b00, 1'b0);

    // reset with all buttons pressed
    espera("reset_1", 4'b0000, 2'd0, 1'b0, 2'b00); tick();
    espera("reset_2", 4'b0000, 2'd0, 1'b0, 2'b00); tick();
    checks++;
    if ({pendientes, objetivo, objetivo_valido, direccion} !== 9'b0) begin
      fails++;
      $display("FAIL direct reset: pend=%b obj=%0d val=%b dir=%b",
               pendientes, objetivo, objetivo_valido, direccion);
    end

    // call floor 2 from idle at floor 0
    rst = 1'b0; llamada = 4'b0100;
    espera("latch_2", 4'b0100, 2'd0, 1'b0, 2'b00); tick();
    llamada = 4'b0000;
    espera("go_up_2", 4'b0100, 2'd2, 1'b1, 2'b01); tick();
    checks++;
    if (pendientes !== 4'b0100 || objetivo !== 2'd2 || objetivo_valido !== 1'b1 || direccion !== 2'b01) begin
      fails++;
      $display("FAIL direct go_up_2: pend=%b obj=%0d val=%b dir=%b",
               pendientes, objetivo, objetivo_valido, direccion);
    end

    // build pendientes=1001 while going up, then reverse at floor 3
    fsm(2'd1, 2'b01, 1'b0); llamada = 4'b1000;
    espera("up_keep_2", 4'b1100, 2'd2, 1'b1, 2'b01); tick();
    fsm(2'd2, 2'b00, 1'b1); llamada = 4'b0001;
    espera("serve_2", 4'b1001, 2'd2, 1'b1, 2'b01); tick();
    fsm(2'd1, 2'b01, 1'b0); llamada = 4'b0000;
    espera("scan_obj_3", 4'b1001, 2'd3, 1'b1, 2'b01); tick();
    fsm(2'd3, 2'b00, 1'b1);
    espera("serve_3", 4'b0001, 2'd3, 1'b1, 2'b01); tick();
    espera("reverse_down", 4'b0001, 2'd0, 1'b1, 2'b10); tick();
    checks++;
    if (direccion !== 2'b10 || objetivo !== 2'd0) begin
      fails++;
      $display("FAIL direct reverse_down: obj=%0d dir=%b", objetivo, direccion);
    end

    // serve floor 0, scheduler returns to idle
    fsm(2'd0, 2'b00, 1'b1);
    espera("serve_0", 4'b0000, 2'd0, 1'b1, 2'b10); tick();
    espera("idle_empty", 4'b0000, 2'd0, 1'b0, 2'b00); tick();

    // distance tie from floor 1 goes up
    fsm(2'd1, 2'b00, 1'b0); llamada = 4'b0101;
    espera("tie_latch", 4'b0101, 2'd0, 1'b0, 2'b00); tick();
    llamada = 4'b0000;
    espera("tie_up", 4'b0101, 2'd2, 1'b1, 2'b01); tick();
    checks++;
    if (objetivo !== 2'd2 || direccion !== 2'b01) begin
      fails++;
      $display("FAIL direct tie_up: obj=%0d dir=%b", objetivo, direccion);
    end
    fsm(2'd2, 2'b00, 1'b1);
    espera("tie_serve_2", 4'b0001, 2'd2, 1'b1, 2'b01); tick();
    espera("tie_reverse", 4'b0001, 2'd0, 1'b1, 2'b10); tick();
    fsm(2'd0, 2'b00, 1'b1);
    espera("tie_serve_0", 4'b0000, 2'd0, 1'b1, 2'b10); tick();
    espera("tie_idle", 4'b0000, 2'd0, 1'b0, 2'b00); tick();

    // press at the open floor is absorbed
    fsm(2'd2, 2'b00, 1'b1); llamada = 4'b0100;
    espera("absorb_1", 4'b0000, 2'd0, 1'b0, 2'b00); tick();
    espera("absorb_2", 4'b0000, 2'd0, 1'b0, 2'b00); tick();
    checks++;
    if (pendientes[2] !== 1'b0 || objetivo_valido !== 1'b0) begin
      fails++;
      $display("FAIL direct absorb: pend=%b val=%b", pendientes, objetivo_valido);
    end

    // get moving toward floor 1, then freeze with en=0
    fsm(2'd0, 2'b00, 1'b0); llamada = 4'b0010;
    espera("pre_en_latch", 4'b0010, 2'd0, 1'b0, 2'b00); tick();
    llamada = 4'b0000;
    espera("pre_en_up", 4'b0010, 2'd1, 1'b1, 2'b01); tick();
    en = 1'b0; llamada = 4'b1000;
    espera("en0_hold_1", 4'b0010, 2'd1, 1'b1, 2'b01); tick();
    espera("en0_hold_2", 4'b0010, 2'd1, 1'b1, 2'b01); tick();
    checks++;
    if (pendientes !== 4'b0010 || objetivo !== 2'd1 || objetivo_valido !== 1'b1 || direccion !== 2'b01) begin
      fails++;
      $display("FAIL direct en0_hold: pend=%b obj=%0d val=%b dir=%b",
               pendientes, objetivo, objetivo_valido, direccion);
    end

    // resume, then reset while going up with pendientes=1010
    en = 1'b1; fsm(2'd0, 2'b01, 1'b0);
    espera("en1_latch", 4'b1010, 2'd1, 1'b1, 2'b01); tick();
    llamada = 4'b0000; rst = 1'b1;
    espera("rst_mid", 4'b0000, 2'd0, 1'b0, 2'b00); tick();
    checks++;
    if ({pendientes, objetivo, objetivo_valido, direccion} !== 9'b0) begin
      fails++;
      $display("FAIL direct rst_mid: pend=%b obj=%0d val=%b dir=%b",
               pendientes, objetivo, objetivo_valido, direccion);
    end
    rst = 1'b0;
    espera("after_rst", 4'b0000, 2'd0, 1'b0, 2'b00); tick();

    tick();
    tick();
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      fails++;
      $display("FAIL %s: never checked (edge %0d), expected pend=%b obj=%0d val=%b dir=%b",
               e.nombre, e.cyc, e.pend, e.obj, e.val, e.dir);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
